// File: rtl/sobel_window_fetch.sv
// Fetches the new pixels of a 3x3 Sobel window after each load/move of the
// window address generator, keeping retained pixels and issuing one read at a time.
module sobel_window_fetch #(
  parameter int ADDR_W = 16,
  parameter int PIX_W  = 8
) (
  input  logic                 clk,
  input  logic                 n_reset,
  input  logic [ADDR_W-1:0]    center_addr,
  input  logic [1:0]           direction,
  input  logic [11:0]          length,
  input  logic                 load_initial,
  input  logic                 step,
  output logic                 mem_ren,
  output logic [ADDR_W-1:0]    mem_addr,
  input  logic [PIX_W-1:0]     mem_rdata,
  input  logic                 mem_rvalid,
  output logic [9*PIX_W-1:0]   window,
  output logic                 window_valid,
  output logic                 busy,
  output logic                 err
);

  localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  typedef enum logic [1:0] {FETCH_ALL, FETCH_COL2, FETCH_COL0, FETCH_ROW2} mode_t;

  state_t            state, state_nx;
  mode_t             mode;
  logic [ADDR_W-1:0] c_lat, l_lat;
  logic [3:0]        idx, idx3, slot, last_idx;
  logic              discard;
  logic [PIX_W-1:0]  pix [9];

  logic accept_load, accept_step, wr_pix, done, set_discard, clr_discard, set_err;

  function automatic logic [ADDR_W-1:0] slot_addr(input logic [3:0]        s,
                                                  input logic [ADDR_W-1:0] c,
                                                  input logic [ADDR_W-1:0] l);
    logic [ADDR_W-1:0] row_base;
    logic [ADDR_W-1:0] a;
    case (s)
      4'd0, 4'd1, 4'd2: row_base = c - l;
      4'd3, 4'd4, 4'd5: row_base = c;
      default:          row_base = c + l;
    endcase
    case (s)
      4'd0, 4'd3, 4'd6: a = row_base - ONE;
      4'd1, 4'd4, 4'd7: a = row_base;
      default:          a = row_base + ONE;
    endcase
    return a;
  endfunction

  // Fetch-list entry idx maps to a window slot according to the move kind
  always_comb begin
    idx3 = {1'b0, idx[1:0], 1'b0} + {2'b00, idx[1:0]};
    case (mode)
      FETCH_ALL:  slot = idx;
      FETCH_COL2: slot = idx3 + 4'd2;
      FETCH_COL0: slot = idx3;
      default:    slot = idx + 4'd6;
    endcase
    last_idx = (mode == FETCH_ALL) ? 4'd8 : 4'd2;
  end

  assign busy = (state != IDLE);
  assign set_err = step && !load_initial && ((state != IDLE) || (direction == 2'b00));

  always_comb begin
    state_nx    = state;
    accept_load = 1'b0;
    accept_step = 1'b0;
    wr_pix      = 1'b0;
    done        = 1'b0;
    set_discard = 1'b0;
    clr_discard = 1'b0;
    mem_ren     = 1'b0;
    mem_addr    = '0;
    case (state)
      IDLE: begin
        if (load_initial) begin
          accept_load = 1'b1;
          state_nx    = ISSUE;
        end else if (step && (direction != 2'b00)) begin
          accept_step = 1'b1;
          state_nx    = ISSUE;
        end
      end
      ISSUE: begin
        mem_ren  = 1'b1;
        mem_addr = slot_addr(slot, c_lat, l_lat);
        state_nx = WAIT;
        // The read strobed this cycle is still owed a response after an abort
        if (load_initial) begin
          accept_load = 1'b1;
          set_discard = 1'b1;
        end
      end
      WAIT: begin
        if (load_initial) begin
          accept_load = 1'b1;
          if (mem_rvalid) state_nx = ISSUE;
          else            set_discard = 1'b1;
        end else if (mem_rvalid) begin
          if (discard) begin
            clr_discard = 1'b1;
            state_nx    = ISSUE;
          end else begin
            wr_pix = 1'b1;
            if (idx == last_idx) begin
              done     = 1'b1;
              state_nx = IDLE;
            end else begin
              state_nx = ISSUE;
            end
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) state <= IDLE;
    else          state <= state_nx;
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      c_lat        <= '0;
      l_lat        <= '0;
      mode         <= FETCH_ALL;
      idx          <= '0;
      discard      <= 1'b0;
      window_valid <= 1'b0;
      err          <= 1'b0;
      for (int i = 0; i < 9; i++) pix[i] <= '0;
    end else begin
      if (set_err) err <= 1'b1;
      if (accept_load || accept_step) begin
        c_lat        <= center_addr;
        l_lat        <= ADDR_W'(length);
        idx          <= '0;
        window_valid <= 1'b0;
      end
      if (accept_load) begin
        mode    <= FETCH_ALL;
        discard <= set_discard;
      end else if (clr_discard) begin
        discard <= 1'b0;
      end
      // Retained pixels move at the accept edge; vacated slots keep stale data
      if (accept_step) begin
        case (direction)
          2'b01: begin
            mode <= FETCH_COL2;
            for (int r = 0; r < 3; r++) begin
              pix[3*r]   <= pix[3*r+1];
              pix[3*r+1] <= pix[3*r+2];
            end
          end
          2'b10: begin
            mode <= FETCH_COL0;
            for (int r = 0; r < 3; r++) begin
              pix[3*r+2] <= pix[3*r+1];
              pix[3*r+1] <= pix[3*r];
            end
          end
          default: begin
            mode <= FETCH_ROW2;
            for (int c = 0; c < 3; c++) begin
              pix[c]   <= pix[3+c];
              pix[3+c] <= pix[6+c];
            end
          end
        endcase
      end
      if (wr_pix) begin
        pix[slot] <= mem_rdata;
        idx       <= idx + 4'd1;
        if (done) window_valid <= 1'b1;
      end
    end
  end

  always_comb begin
    window = '0;
    for (int i = 0; i < 9; i++) window[i*PIX_W +: PIX_W] = pix[i];
  end

endmodule

// File: tb/tb_sobel_window_fetch.sv
// Bench for sobel_window_fetch: vector table, scoreboarded read addresses,
// a memory that returns the low address byte, and multi-cycle corner sequences.
module tb_sobel_window_fetch;

  logic        clk = 1'b0;
  logic        n_reset = 1'b0;
  logic [15:0] center_addr = '0;
  logic [1:0]  direction = '0;
  logic [11:0] length = '0;
  logic        load_initial = 1'b0;
  logic        step = 1'b0;
  logic        mem_ren;
  logic [15:0] mem_addr;
  logic [7:0]  mem_rdata = '0;
  logic        mem_rvalid = 1'b0;
  logic [71:0] window;
  logic        window_valid;
  logic        busy;
  logic        err;

  sobel_window_fetch #(.ADDR_W(16), .PIX_W(8)) dut (
    .clk(clk), .n_reset(n_reset), .center_addr(center_addr), .direction(direction),
    .length(length), .load_initial(load_initial), .step(step), .mem_ren(mem_ren),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .window(window), .window_valid(window_valid), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [15:0] exp_q[$];
  int  lat_fixed = 1;
  bit  lat_rand = 1'b0;
  bit  pend = 1'b0;
  int  cnt = 0;
  logic [15:0] paddr = '0;
  logic [15:0] exp_a;

  typedef struct {
    bit          ld;
    bit          st;
    logic [1:0]  dir;
    logic [15:0] c;
    logic [11:0] l;
    int          cyc;
    logic [71:0] win;
  } vec_t;

  vec_t tbl[4];
  logic [1:0]  mdir[7];
  logic [15:0] mc[7];

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] nb_addr(input logic [15:0] c, input logic [11:0] l, input int s);
    int a;
    a = int'(c) + (s / 3 - 1) * int'(l) + (s % 3 - 1);
    return a[15:0];
  endfunction

  function automatic logic [71:0] exp_window(input logic [15:0] c, input logic [11:0] l);
    logic [71:0] w;
    logic [15:0] a;
    w = '0;
    for (int s = 0; s < 9; s++) begin
      a = nb_addr(c, l, s);
      w[s*8 +: 8] = a[7:0];
    end
    return w;
  endfunction

  task automatic push_addrs(input bit ld, input logic [1:0] dir, input logic [15:0] c,
                            input logic [11:0] l);
    if (ld) begin
      for (int s = 0; s < 9; s++) exp_q.push_back(nb_addr(c, l, s));
    end else begin
      for (int k = 0; k < 3; k++) begin
        case (dir)
          2'b01: exp_q.push_back(nb_addr(c, l, 3*k + 2));
          2'b10: exp_q.push_back(nb_addr(c, l, 3*k));
          2'b11: exp_q.push_back(nb_addr(c, l, 6 + k));
          default: ;
        endcase
      end
    end
  endtask

  // Memory: one response per strobe after 1..4 cycles; reads are checked
  // against the scoreboard and must never overlap an outstanding read.
  always @(posedge clk) begin
    if (mem_ren) begin
      check("ren_while_outstanding", {71'd0, (pend | mem_rvalid)}, 72'd0);
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_read: got addr %0h expected no read", mem_addr);
      end else begin
        exp_a = exp_q.pop_front();
        check("rd_addr", 72'(mem_addr), 72'(exp_a));
      end
      pend  = 1'b1;
      paddr = mem_addr;
      cnt   = lat_rand ? int'($urandom_range(1, 4)) : lat_fixed;
    end
    mem_rvalid <= 1'b0;
    if (pend) begin
      cnt--;
      if (cnt == 0) begin
        mem_rvalid <= 1'b1;
        mem_rdata  <= paddr[7:0];
        pend = 1'b0;
      end
    end
  end

  task automatic request(input bit ld, input bit st, input logic [1:0] dir,
                         input logic [15:0] c, input logic [11:0] l, input int exp_cyc,
                         input logic [71:0] exp_win, input int conflict_at, input string name);
    int n;
    if (ld || st) push_addrs(ld, dir, c, l);
    load_initial = ld;
    step         = st;
    direction    = dir;
    center_addr  = c;
    length       = l;
    @(posedge clk); #1;
    load_initial = 1'b0;
    step         = 1'b0;
    n = 1;
    check({name, "_busy"}, 72'(busy), 72'd1);
    check({name, "_vld_low"}, 72'(window_valid), 72'd0);
    while (!window_valid && n < 400) begin
      if (n == conflict_at) begin
        step        = 1'b1;
        direction   = 2'b10;
        center_addr = 16'h0200;
      end
      @(posedge clk); #1;
      step = 1'b0;
      n++;
    end
    check({name, "_valid"}, 72'(window_valid), 72'd1);
    if (exp_cyc != 0) check({name, "_cycles"}, 72'(n), 72'(exp_cyc));
    check({name, "_window"}, window, exp_win);
    check({name, "_reads_left"}, 72'(exp_q.size()), 72'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{1'b1, 1'b0, 2'b00, 16'h0105, 12'h040, 19, 72'h46_45_44_06_05_04_C6_C5_C4};
    tbl[1] = '{1'b0, 1'b1, 2'b01, 16'h0106, 12'h040, 7,  72'h47_46_45_07_06_05_C7_C6_C5};
    tbl[2] = '{1'b0, 1'b1, 2'b10, 16'h0105, 12'h040, 7,  72'h46_45_44_06_05_04_C6_C5_C4};
    tbl[3] = '{1'b0, 1'b1, 2'b11, 16'h0145, 12'h040, 7,  72'h86_85_84_46_45_44_06_05_04};
    mdir = '{2'b01, 2'b01, 2'b11, 2'b10, 2'b10, 2'b11, 2'b01};
    mc   = '{16'h0306, 16'h0307, 16'h0347, 16'h0346, 16'h0345, 16'h0385, 16'h0386};

    repeat (3) @(posedge clk);
    #1 n_reset = 1'b1;
    @(posedge clk); #1;
    check("rst_window", window, 72'd0);
    check("rst_valid", 72'(window_valid), 72'd0);
    check("rst_busy", 72'(busy), 72'd0);
    check("rst_err", 72'(err), 72'd0);
    check("rst_ren", 72'(mem_ren), 72'd0);
    check("rst_addr", 72'(mem_addr), 72'd0);

    for (int i = 0; i < 4; i++)
      request(tbl[i].ld, tbl[i].st, tbl[i].dir, tbl[i].c, tbl[i].l, tbl[i].cyc, tbl[i].win, 0,
              $sformatf("vec%0d", i));
    check("err_after_table", 72'(err), 72'd0);

    request(1'b1, 1'b1, 2'b01, 16'h0205, 12'h040, 19, exp_window(16'h0205, 12'h040), 0,
            "ld_and_step");
    check("err_ld_and_step", 72'(err), 72'd0);

    request(1'b0, 1'b1, 2'b01, 16'h0206, 12'h040, 7, exp_window(16'h0206, 12'h040), 3,
            "step_busy");
    check("err_step_busy", 72'(err), 72'd1);

    // Reset mid-fetch with a read still in flight at the memory
    lat_fixed = 3;
    push_addrs(1'b1, 2'b00, 16'h0305, 12'h040);
    load_initial = 1'b1; center_addr = 16'h0305; length = 12'h040;
    @(posedge clk); #1;
    load_initial = 1'b0;
    @(posedge clk); #1;
    n_reset = 1'b0;
    #1;
    check("midrst_window", window, 72'd0);
    check("midrst_valid", 72'(window_valid), 72'd0);
    check("midrst_busy", 72'(busy), 72'd0);
    check("midrst_err", 72'(err), 72'd0);
    check("midrst_ren", 72'(mem_ren), 72'd0);
    check("midrst_addr", 72'(mem_addr), 72'd0);
    exp_q.delete();
    @(posedge clk); #1;
    n_reset = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("stray_window", window, 72'd0);
    check("stray_valid", 72'(window_valid), 72'd0);
    check("stray_busy", 72'(busy), 72'd0);
    lat_fixed = 1;

    // Step with no direction: flags err, leaves window and valid alone
    request(1'b1, 1'b0, 2'b00, 16'h0105, 12'h040, 19, exp_window(16'h0105, 12'h040), 0, "reload");
    step = 1'b1; direction = 2'b00; center_addr = 16'h0106;
    @(posedge clk); #1;
    step = 1'b0;
    check("dir0_err", 72'(err), 72'd1);
    check("dir0_busy", 72'(busy), 72'd0);
    check("dir0_valid", 72'(window_valid), 72'd1);
    repeat (4) @(posedge clk);
    #1;
    check("dir0_window", window, 72'h46_45_44_06_05_04_C6_C5_C4);
    check("dir0_no_reads", 72'(exp_q.size()), 72'd0);

    // Abort a load while its first read is outstanding
    lat_fixed = 2;
    push_addrs(1'b1, 2'b00, 16'h0105, 12'h040);
    load_initial = 1'b1; center_addr = 16'h0105; length = 12'h040;
    @(posedge clk); #1;
    load_initial = 1'b0;
    @(posedge clk); #1;
    exp_q.delete();
    request(1'b1, 1'b0, 2'b00, 16'h0305, 12'h040, 0, exp_window(16'h0305, 12'h040), 0,
            "abort_reload");

    lat_rand = 1'b1;
    for (int i = 0; i < 7; i++)
      request(1'b0, 1'b1, mdir[i], mc[i], 12'h040, 0, exp_window(mc[i], 12'h040), 0,
              $sformatf("waitst%0d", i));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sobel_window_fetch.md
# sobel_window_fetch

Pixel-side responder to the serpentine window address generator. Each time the generator reports a completed load or move, the block fetches only the new pixels of the 3x3 Sobel neighbourhood from image memory, shifts the retained pixels, and presents the full window to the gradient datapath. It sits between the address generator/controller and the image SRAM read port, and uses a single outstanding read.

## Interface
- ADDR_W, 16, image memory address width
- PIX_W, 8, pixel width
- clk  input  1  rising-edge clock
- n_reset  input  1  asynchronous active-low reset
- center_addr  input  ADDR_W  address of the window centre pixel, valid with load_initial/step
- direction  input  2  move just performed: 01 right, 10 left, 11 down (+length), 00 none
- length  input  12  row stride in pixels
- load_initial  input  1  one-cycle pulse: fetch all 9 pixels
- step  input  1  one-cycle pulse: window moved by direction
- mem_ren  output  1  read strobe, one cycle per read
- mem_addr  output  ADDR_W  read address, valid while mem_ren=1
- mem_rdata  input  PIX_W  read data, valid with mem_rvalid
- mem_rvalid  input  1  read data valid, at least 1 cycle after mem_ren
- window  output  9*PIX_W  p0..p8 row-major (p[r*3+c], r0 = top row, c0 = left column); p0 in LSBs
- window_valid  output  1  window complete and consistent with the last request
- busy  output  1  fetch in progress
- err  output  1  sticky: step received while busy, or step with direction 00

## Operation
- States: IDLE, ISSUE, WAIT. busy = (state != IDLE).
- IDLE + load_initial: latch C = center_addr and L = length (zero-extended/truncated to ADDR_W). Set the fetch list to all 9 offsets in row-major order: C-L-1, C-L, C-L+1, C-1, C, C+1, C+L-1, C+L, C+L+1. Clear window_valid. Go to ISSUE.
- IDLE + step (load_initial low): latch C and L, then branch on direction:
  - 01: shift columns left (c0<-c1, c1<-c2). Fetch column 2: C-L+1, C+1, C+L+1.
  - 10: shift columns right. Fetch column 0: C-L-1, C-1, C+L-1.
  - 11: shift rows up (r0<-r1, r1<-r2). Fetch row 2: C+L-1, C+L, C+L+1.
  - 00: set err, no fetch, window unchanged, window_valid stays as it was.
  - The shift is applied at the accept edge. Target slots hold stale data until overwritten.
- ISSUE: mem_ren=1 and mem_addr = current list entry for exactly one cycle, then go to WAIT.
- WAIT: on mem_rvalid, write mem_rdata into the target slot and advance the index. If entries remain, go to ISSUE. Otherwise go to IDLE and set window_valid=1 on the same edge.
- load_initial in any busy state aborts the current fetch and restarts a full 9-pixel load with the new C, L. Any in-flight rvalid belonging to the aborted read is consumed and discarded: the block waits for it before issuing.
- step while busy: ignored, err=1.
- load_initial and step in the same cycle: load_initial wins, step ignored, no err.
- mem_rvalid in IDLE or ISSUE: ignored.
- Address arithmetic is modulo 2^ADDR_W. No bounds checking; the generator keeps the centre interior.

## Timing
- Reset values: state IDLE, window all zeros, window_valid 0, busy 0, err 0, mem_ren 0, mem_addr 0. err clears only on reset.
- Request sampled at edge E0. Then busy=1, window_valid=0, and ISSUE runs during the cycle after E0.
- With 1-cycle memory latency, each pixel costs 2 cycles:
  - step: window_valid=1 and busy=0 in the cycle after the 3rd rvalid, i.e. 7 cycles after the request cycle.
  - load_initial: 19 cycles after the request cycle.
- Each extra wait-state cycle on mem_rvalid adds exactly 1 cycle per pixel.
- Reset mid-fetch: all state returns immediately to reset values. A later rvalid is ignored.

## Test plan
- Full load: memory returns the low byte of the address, 1-cycle latency; load_initial with C=0x0105, L=0x0040. Expect:
  - 9 reads at C-L-1 through C+L+1 in row-major order;
  - window = {0x46,0x45,0x44,0x06,0x05,0x04,0xC6,0xC5,0xC4} from p8 down to p0;
  - window_valid high in cycle 19.
- Right step: then step, dir=01, C=0x0106. Expect reads 0x00C7, 0x0107, 0x0147; old columns 1-2 shifted to columns 0-1; window_valid in cycle 7.
- Left and down: step dir=10, C=0x0105 -> reads 0x00C4, 0x0104, 0x0144. Then step dir=11, C=0x0145 -> reads 0x0184, 0x0185, 0x0186; rows shifted up.
- Conflicts: step during a fetch -> err=1, fetch continues unchanged. load_initial mid-fetch -> aborted read's rvalid is discarded; 9 new reads follow.
- Wait states: random 1-4 cycle mem_rvalid delay. Window contents match the model and mem_ren never rises while a read is outstanding.
- Reset: assert n_reset low mid-fetch. All outputs are 0 immediately; a stray mem_rvalid after release does not alter window.
